// File: rtl/stopwatch_input_ctrl.sv
// Stopwatch front end: synchronizes/debounces buttons and the adjust switch, then drives the
// pause level, a one-cycle clear pulse, and one-cycle digit-write strobes for adjust mode.
module stopwatch_input_ctrl #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_rst,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic       sw_adj,
    output logic       paused,
    output logic       rst_out,
    output logic       adj,
    output logic [2:0] adj_sel,
    output logic [3:0] adj_val,
    output logic [2:0] cur_sel
);

    localparam int N_IN   = 5;
    localparam int I_PAUSE = 0;
    localparam int I_CLR   = 1;
    localparam int I_SEL   = 2;
    localparam int I_INC   = 3;
    localparam int I_ADJ   = 4;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {ST_IDLE, ST_SELECT} state_t;

    logic [N_IN-1:0]  w_raw;
    logic [N_IN-1:0]  r_sync1;
    logic [N_IN-1:0]  r_sync2;
    logic [N_IN-1:0]  r_stable;
    logic [N_IN-1:0]  r_prev;
    logic [CNT_W-1:0] r_cnt [N_IN];
    logic [N_IN-1:0]  w_press;
    logic             w_adj_fall;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_sel_idx, w_sel_nxt;
    logic [3:0] r_dig [4];
    logic [3:0] w_dig_nxt [4];
    logic [2:0] r_adj_sel, w_adj_sel_nxt;
    logic [3:0] r_adj_val, w_adj_val_nxt;
    logic       r_paused, w_paused_nxt;
    logic       r_rst_out, w_rst_out_nxt;
    logic [1:0] w_idx;
    logic [3:0] w_cur;
    logic [3:0] w_new;

    assign w_raw = {sw_adj, btn_inc, btn_sel, btn_rst, btn_pause};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_prev   <= '0;
            for (int i = 0; i < N_IN; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_stable;
            for (int i = 0; i < N_IN; i++) begin
                if (r_sync2[i] != r_stable[i]) begin
                    if (r_cnt[i] == DB_LAST) begin
                        r_stable[i] <= r_sync2[i];
                        r_cnt[i]    <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_ONE;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_press    = r_stable & ~r_prev;
    assign w_adj_fall = ~r_stable[I_ADJ] & r_prev[I_ADJ];

    // sel_idx is 1-based; digit array index is sel_idx-1
    assign w_idx = 2'(r_sel_idx - 3'd1);
    assign w_cur = r_dig[w_idx];

    function automatic logic [3:0] dig_max(input logic [2:0] sel);
        return (sel == 3'd3) ? 4'd5 : 4'd9;
    endfunction

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel_idx;
        w_dig_nxt     = r_dig;
        w_adj_sel_nxt = '0;
        w_adj_val_nxt = '0;
        w_paused_nxt  = r_paused;
        w_rst_out_nxt = 1'b0;
        w_new         = (w_cur == dig_max(r_sel_idx)) ? 4'd0 : w_cur + 4'd1;

        case (r_state)
            ST_IDLE: begin
                if (w_press[I_ADJ]) begin
                    w_state_nxt = ST_SELECT;
                    w_sel_nxt   = 3'd1;
                end
            end
            ST_SELECT: begin
                if (w_adj_fall) begin
                    w_state_nxt = ST_IDLE;
                    w_sel_nxt   = 3'd0;
                end else if (!w_press[I_CLR]) begin
                    // increment targets the pre-advance selection
                    if (w_press[I_INC]) begin
                        w_dig_nxt[w_idx] = w_new;
                        w_adj_sel_nxt    = r_sel_idx;
                        w_adj_val_nxt    = w_new;
                    end
                    if (w_press[I_SEL])
                        w_sel_nxt = (r_sel_idx == 3'd4) ? 3'd1 : r_sel_idx + 3'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_press[I_CLR]) begin
            w_rst_out_nxt = 1'b1;
            w_paused_nxt  = 1'b1;
            for (int i = 0; i < 4; i++) w_dig_nxt[i] = 4'd0;
        end else if (r_stable[I_ADJ]) begin
            w_paused_nxt = 1'b1;
        end else if (w_press[I_PAUSE]) begin
            w_paused_nxt = ~r_paused;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sel_idx <= '0;
            for (int i = 0; i < 4; i++) r_dig[i] <= '0;
            r_adj_sel <= '0;
            r_adj_val <= '0;
            r_paused  <= 1'b1;
            r_rst_out <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel_idx <= w_sel_nxt;
            r_dig     <= w_dig_nxt;
            r_adj_sel <= w_adj_sel_nxt;
            r_adj_val <= w_adj_val_nxt;
            r_paused  <= w_paused_nxt;
            r_rst_out <= w_rst_out_nxt;
        end
    end

    assign paused  = r_paused;
    assign rst_out = r_rst_out;
    assign adj     = r_stable[I_ADJ];
    assign adj_sel = r_adj_sel;
    assign adj_val = r_adj_val;
    assign cur_sel = (r_state == ST_SELECT) ? r_sel_idx : 3'd0;

endmodule

// File: tb/tb_stopwatch_input_ctrl.sv
// Directed bench for stopwatch_input_ctrl with a short debounce window.
module tb_stopwatch_input_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_pause, btn_rst, btn_sel, btn_inc, sw_adj;
    logic       paused, rst_out, adj;
    logic [2:0] adj_sel, cur_sel;
    logic [3:0] adj_val;

    int errs   = 0;
    int checks = 0;
    int n_str, n_rst, n_unp, n_badval;
    logic [2:0] s_sel, s_cur;
    logic [3:0] s_val;
    logic       s_pau;
    logic       ok;

    stopwatch_input_ctrl #(.DB_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .btn_pause(btn_pause), .btn_rst(btn_rst), .btn_sel(btn_sel),
        .btn_inc(btn_inc), .sw_adj(sw_adj),
        .paused(paused), .rst_out(rst_out), .adj(adj),
        .adj_sel(adj_sel), .adj_val(adj_val), .cur_sel(cur_sel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (adj_sel != 3'd0) begin
                n_str++;
                s_sel = adj_sel;
                s_val = adj_val;
                s_cur = cur_sel;
            end else if (adj_val != 4'd0) begin
                n_badval++;
            end
            if (rst_out) begin
                n_rst++;
                s_pau = paused;
            end
            if (!paused) n_unp++;
        end
    endtask

    task automatic press(input logic p, input logic r, input logic s, input logic inc);
        n_str = 0; n_rst = 0; n_unp = 0;
        btn_pause = p; btn_rst = r; btn_sel = s; btn_inc = inc;
        hold(10);
        btn_pause = 0; btn_rst = 0; btn_sel = 0; btn_inc = 0;
        hold(10);
    endtask

    initial begin
        n_badval = 0; n_str = 0; n_rst = 0; n_unp = 0;
        s_sel = 0; s_val = 0; s_cur = 0; s_pau = 0;
        btn_pause = 0; btn_rst = 0; btn_sel = 0; btn_inc = 0; sw_adj = 0;
        rst = 1;
        tick(); tick(); tick();
        rst = 0;
        tick();
        chk("rst_paused",  paused,  1);
        chk("rst_rst_out", rst_out, 0);
        chk("rst_adj",     adj,     0);
        chk("rst_adj_sel", adj_sel, 0);
        chk("rst_adj_val", adj_val, 0);
        chk("rst_cur_sel", cur_sel, 0);

        // bounce: 2-cycle pulses never satisfy the 4-cycle window
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            btn_pause = ((i / 2) % 2) == 0;
            tick();
            if (!paused) ok = 0;
        end
        btn_pause = 1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (!paused) ok = 0;
        end
        chk("bounce_no_early_change", ok, 1);
        tick();
        chk("pause_flip_at_7", paused, 0);
        btn_pause = 0;
        hold(10);
        chk("pause_release_no_toggle", paused, 0);

        press(0, 1, 0, 0);
        chk("clr_pulse_count", n_rst, 1);
        chk("clr_paused_same_cycle", s_pau, 1);
        chk("clr_paused_after", paused, 1);

        sw_adj = 1;
        hold(10);
        chk("adj_on", adj, 1);
        chk("adj_cur_sel_1", cur_sel, 1);
        press(0, 0, 1, 0);
        chk("sel_to_2", cur_sel, 2);
        press(0, 0, 1, 0);
        chk("sel_to_3", cur_sel, 3);

        for (int i = 0; i < 6; i++) begin
            press(0, 0, 0, 1);
            chk("secl_strobe_count", n_str, 1);
            chk("secl_strobe_sel", s_sel, 3);
            chk("secl_strobe_val", s_val, (i + 1) % 6);
        end

        press(0, 0, 1, 0);
        chk("sel_to_4", cur_sel, 4);
        for (int i = 0; i < 9; i++) begin
            press(0, 0, 0, 1);
            chk("secr_strobe_one", (n_str == 1) && (s_sel == 3'd4), 1);
            chk("secr_strobe_val", s_val, i + 1);
        end

        press(0, 0, 1, 1);
        chk("simul_strobe_count", n_str, 1);
        chk("simul_strobe_sel", s_sel, 4);
        chk("simul_strobe_val", s_val, 0);
        chk("simul_cur_sel_strobe", s_cur, 1);
        chk("simul_cur_sel_after", cur_sel, 1);

        press(1, 0, 0, 0);
        chk("adj_pause_lockout", n_unp, 0);
        chk("adj_pause_level", paused, 1);

        sw_adj = 0;
        hold(10);
        chk("adj_off", adj, 0);
        chk("adj_off_cur_sel", cur_sel, 0);
        press(1, 0, 0, 0);
        chk("pause_after_adj", paused, 0);

        // reset in the middle of a debounce window
        sw_adj = 1;
        hold(10);
        chk("adj_on_again", cur_sel, 1);
        btn_inc = 1;
        hold(5);
        rst = 1;
        #1;
        chk("midrst_paused", paused, 1);
        chk("midrst_cur_sel", cur_sel, 0);
        btn_inc = 0; sw_adj = 0;
        tick();
        rst = 0;
        n_str = 0;
        hold(10);
        chk("postrst_no_strobe", n_str, 0);
        chk("postrst_adj", adj, 0);
        chk("postrst_paused", paused, 1);
        chk("val_zero_without_strobe", n_badval, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_input_ctrl.md
Name: stopwatch_input_ctrl

Overview:
- Front end that drives the stopwatch counter's control inputs: paused, rst, adj, adj_sel, adj_val.
- Synchronizes and debounces raw pushbuttons and the adjust switch.
- Turns button presses into a pause toggle and a one-cycle counter-reset pulse.
- In adjust mode, runs a digit-select and increment state machine that emits one-cycle digit-write strobes. The counter consumes these strobes.

Parameters:
- DB_CYCLES, 500000: consecutive stable clk cycles required before a debounced input changes state. The bench uses 4.
- CNT_W, 20: width of each debounce counter. Must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_pause  in  1  raw pause button, asynchronous to clk
- btn_rst  in  1  raw clear button, asynchronous to clk
- btn_sel  in  1  raw digit-select button, asynchronous to clk
- btn_inc  in  1  raw digit-increment button, asynchronous to clk
- sw_adj  in  1  raw adjust-mode switch, asynchronous to clk
- paused  out  1  stopwatch halted while 1
- rst_out  out  1  one-cycle counter clear pulse
- adj  out  1  debounced adjust-mode level
- adj_sel  out  3  digit-write strobe: 0 none, 1 min_l, 2 min_r, 3 sec_l, 4 sec_r
- adj_val  out  4  value to write; valid only when adj_sel != 0
- cur_sel  out  3  currently selected digit, same encoding; 0 when not in adjust mode

Behaviour:
- Async reset clears: rst_out, adj, adj_sel, adj_val, cur_sel, sel_idx, all shadow digits, all sync and debounce state. paused resets to 1.
- Input conditioning:
  - Each raw input passes through a 2-flop synchronizer.
  - Each debouncer holds a stable value (reset 0) and a counter.
  - Counter increments while the synchronized sample differs from the stable value and clears when they match.
  - When the counter reaches DB_CYCLES-1 and the sample still differs, the stable value flips and the counter clears.
  - Press = rising edge of a stable button value, one cycle wide. Releases generate nothing.
- Shadow digits:
  - Four internal 4-bit registers mirror the counter: min_l, min_r, sec_l, sec_r.
  - Maximums: min_l 9, min_r 9, sec_l 5, sec_r 9.
- Clear press:
  - rst_out=1 on the next cycle, for exactly one cycle.
  - Shadow digits go to 0 and paused goes to 1.
  - Takes priority over every other press in the same cycle; no strobe is emitted that cycle.
- Pause press:
  - When adj=0, toggles paused (registered, 1-cycle latency).
  - When adj=1, ignored; paused is held at 1 for the whole adjust session.
- adj output = stable sw_adj value.
- Adjust FSM states: IDLE, SELECT.
  - IDLE -> SELECT on adj rising: sel_idx=1.
  - SELECT -> IDLE on adj falling: sel_idx=0, and any pending strobe is dropped.
  - In SELECT, a btn_sel press advances sel_idx 1->2->3->4->1.
  - In SELECT, a btn_inc press sets the selected shadow digit to 0 if it equals its maximum, else +1.
  - On the cycle after an inc press: adj_sel=sel_idx and adj_val=new digit value, for exactly one cycle. Otherwise adj_sel=0 and adj_val=0.
  - Inc and sel pressed in the same cycle: the increment applies to the old sel_idx, then sel_idx advances.
  - Presses in IDLE do nothing except clear and pause.
- Shadow digit values above their maximum are unreachable; no increment path produces them.
- cur_sel = sel_idx in SELECT, else 0.
- Reset asserted mid-debounce or mid-strobe aborts immediately. Post-reset outputs equal the reset values; no residual strobe appears.

Test Plan:
- Reset checks, DB_CYCLES=4: assert rst, then release -> paused=1; rst_out, adj, adj_sel, adj_val, cur_sel all 0.
- Bounce rejection: btn_pause toggles every 2 cycles for 20 cycles, then held high for 10 -> paused flips exactly once, to 0, 2+4 cycles after the stable high begins (+1 for the register); no earlier change.
- Clear press: btn_rst held high 10 cycles while paused=0 -> rst_out high for exactly one cycle; paused=1 the same cycle.
- Wrap and strobe:
  - sw_adj=1 -> cur_sel=1; btn_sel pressed twice -> cur_sel=3.
  - Six btn_inc presses -> adj_sel=3 strobes with adj_val 1,2,3,4,5,0.
  - adj_sel=0 between strobes.
- Simultaneous press: cur_sel=4 with sec_r=9; btn_inc and btn_sel debounce in the same cycle -> strobe adj_sel=4, adj_val=0; cur_sel=1 the next cycle.
- Adjust exit and pause lockout:
  - btn_pause press during adj=1 -> paused stays 1.
  - sw_adj=0 -> cur_sel=0, adj=0.
  - Next btn_pause press -> paused=0.
